bit_clock_aligner: RTL

Parametrised successor to the fixed ÷4 bit-clock divider. It divides the ADC DCLK by a programmable ratio and phase-aligns the divided clock to the ADC frame clock (FCLK). A lock state machine sits between the LVDS clock input buffers and the deserializer byte/word logic. It reports lock status and alignment errors and also supports manual bit-slip.

---
 rtl/bit_clk_pkg.sv | 18 +
 rtl/bit_clock_aligner_fclk_edge_sync.sv | 26 ++
 rtl/bit_clock_aligner.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bit_clk_pkg.sv
// Shared state encoding, default ratio and width helper for the bit-clock aligner.
package bit_clk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } align_state_t;

  localparam int unsigned DIV_RATIO_DEFAULT = 4;

  // Phase counter width; never below one bit.
  function automatic int unsigned phase_w(input int unsigned ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/bit_clock_aligner_fclk_edge_sync.sv
// Frame-clock synchronizer followed by a registered rising-edge pulse.
module fclk_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in_int,
  input  logic clk_reset,
  input  logic fclk_in,
  output logic fe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_in_int or posedge clk_reset) begin
    if (clk_reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fe     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], fclk_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      fe     <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/bit_clock_aligner.sv
// Divides the DCLK bit clock by DIV_RATIO and phase-locks the divided clock to FCLK.
// Define BIT_CLK_ALIGN_STATS_EN to add the relock_cnt / last_err_phase statistics ports.
module bit_clock_aligner
  import bit_clk_pkg::*;
#(
  parameter int unsigned  DIV_RATIO    = DIV_RATIO_DEFAULT,
  parameter int unsigned  TARGET_PHASE = 0,
  parameter int unsigned  LOCK_COUNT   = 8,
  parameter int unsigned  MISS_LIMIT   = 3,
  localparam int unsigned CNT_W        = phase_w(DIV_RATIO)
) (
  input  logic             clk_in_int,
  input  logic             clk_reset,
  input  logic             fclk_in,
  input  logic             align_en,
  input  logic             slip_req,
  output logic             clk_div_out,
  output logic [CNT_W-1:0] div_phase,
  output logic             locked,
  output logic             align_err,
  output logic [1:0]       state_out
`ifdef BIT_CLK_ALIGN_STATS_EN
  ,
  output logic [7:0]       relock_cnt,
  output logic [CNT_W-1:0] last_err_phase
`endif
);

  localparam int unsigned      MATCH_W   = 8;
  localparam int unsigned      MISS_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0] TGT       = CNT_W'(TARGET_PHASE);
  localparam logic [CNT_W-1:0] TGT_NEXT  = CNT_W'((TARGET_PHASE + 1) % DIV_RATIO);
  // High for the last floor(R/2) phases, so odd ratios get the shorter high half.
  localparam logic [CNT_W-1:0] HIGH_FROM = CNT_W'(DIV_RATIO - DIV_RATIO / 2);
  localparam logic [MATCH_W-1:0] LOCK_N  = MATCH_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  MISS_N  = MISS_W'(MISS_LIMIT);

  // Reset asserts asynchronously and releases on the second clock edge.
  logic rst_meta;
  logic rst_int;

  always_ff @(posedge clk_in_int or posedge clk_reset) begin
    if (clk_reset) begin
      rst_meta <= 1'b1;
      rst_int  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_int  <= rst_meta;
    end
  end

  logic fe;

  fclk_edge_sync #(
    .SYNC_STAGES(2)
  ) u_fclk_sync (
    .clk_in_int(clk_in_int),
    .clk_reset (rst_int),
    .fclk_in   (fclk_in),
    .fe        (fe)
  );

  align_state_t       state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
  logic [MATCH_W-1:0] match, match_next, match_inc;
  logic [MISS_W-1:0]  miss, miss_next, miss_inc;
  logic               locked_next;
  logic               err_next;
  logic               phase_ok;

  assign cnt_inc   = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
  assign match_inc = (match == '1) ? match : match + MATCH_W'(1);
  assign miss_inc  = (miss == '1) ? miss : miss + MISS_W'(1);
  assign phase_ok  = (cnt == TGT);

  // Next-state, counter steering and status decisions.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt_inc;
    match_next  = match;
    miss_next   = miss;
    locked_next = locked;
    err_next    = 1'b0;

    if (!align_en && slip_req) begin
      cnt_next = cnt;
    end

    if (!align_en) begin
      state_next  = IDLE;
      locked_next = 1'b0;
      match_next  = '0;
      miss_next   = '0;
    end else begin
      case (state)
        IDLE: state_next = SEARCH;
        SEARCH: begin
          if (fe) begin
            if (!phase_ok) begin
              cnt_next = TGT_NEXT;
            end
            match_next = '0;
            state_next = CHECK;
          end
        end
        CHECK: begin
          if (fe) begin
            if (phase_ok) begin
              match_next = match_inc;
              if (match_inc >= LOCK_N) begin
                state_next  = LOCKED;
                locked_next = 1'b1;
                miss_next   = '0;
              end
            end else begin
              state_next = SEARCH;
              match_next = '0;
              err_next   = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (fe) begin
            if (phase_ok) begin
              miss_next = '0;
            end else begin
              miss_next = miss_inc;
              if (miss_inc >= MISS_N) begin
                state_next  = SEARCH;
                locked_next = 1'b0;
                miss_next   = '0;
                err_next    = 1'b1;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in_int or posedge rst_int) begin
    if (rst_int) begin
      state       <= IDLE;
      cnt         <= '0;
      match       <= '0;
      miss        <= '0;
      clk_div_out <= 1'b0;
      locked      <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      match       <= match_next;
      miss        <= miss_next;
      clk_div_out <= (cnt_next >= HIGH_FROM);
      locked      <= locked_next;
      align_err   <= err_next;
    end
  end

  assign div_phase = cnt;
  assign state_out = state;

`ifdef BIT_CLK_ALIGN_STATS_EN
  logic relock_evt;
  logic mismatch_fe;

  assign relock_evt  = (state == LOCKED) && (state_next == SEARCH);
  assign mismatch_fe = fe && align_en && (state != IDLE) && !phase_ok;

  always_ff @(posedge clk_in_int or posedge rst_int) begin
    if (rst_int) begin
      relock_cnt     <= '0;
      last_err_phase <= '0;
    end else begin
      if (relock_evt && (relock_cnt != 8'hFF)) begin
        relock_cnt <= relock_cnt + 8'd1;
      end
      if (mismatch_fe) begin
        last_err_phase <= cnt;
      end
    end
  end
`endif

endmodule
